// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control sequencer:
// opcodes, micro-step encoding, IR field positions and strobe bundle.
package cpu_defs;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    T0     = 4'd0,
    T1     = 4'd1,
    T2     = 4'd2,
    T3     = 4'd3,
    T4     = 4'd4,
    T5     = 4'd5,
    T6     = 4'd6,
    HALTED = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_MULDIV,
    CLS_HALT
  } opclass_t;

  typedef struct packed {
    logic pcout;
    logic marin;
    logic incpc;
    logic zin;
    logic zlowout;
    logic zhighout;
    logic pcin;
    logic read;
    logic mdrin;
    logic mdrout;
    logic irin;
    logic yin;
    logic hiin;
    logic loin;
  } strobes_t;

  function automatic opclass_t op_class(
    input logic [4:0] op
  );
    opclass_t c;
    unique case (1'b1)
      (op >= OP_ADD && op <= OP_ROR): c = CLS_ALU;
      (op == OP_MUL || op == OP_DIV): c = CLS_MULDIV;
      (op == OP_HALT):                c = CLS_HALT;
      default:                        c = CLS_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Picks the Ra/Rb/Rc field of IR and expands it into
// one-hot register load and drive enables.
module reg_select_decoder
  import cpu_defs::*;
#(
  parameter int NREGS = 16
) (
  input  logic [31:0]      IR,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rin_en,
  input  logic             Rout_en,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout
);

  logic [3:0]  sel;
  logic        unused_ir;

  assign unused_ir = ^{IR[OP_HI:OP_LO], IR[RC_LO-1:0]};

  always_comb begin
    sel = 4'd0;
    unique case (1'b1)
      Gra:     sel = IR[RA_HI:RA_LO];
      Grb:     sel = IR[RB_HI:RB_LO];
      Grc:     sel = IR[RC_HI:RC_LO];
      default: sel = 4'd0;
    endcase
  end

  always_comb begin
    Rin  = '0;
    Rout = '0;
    if (Rin_en)  Rin  = NREGS'(1) << sel;
    if (Rout_en) Rout = NREGS'(1) << sel;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control unit: sequences fetch/execute and
// drives the datapath register-transfer strobes from state + IR.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             stop,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [OPW-1:0]   opcode,
  output logic             run,
  output logic [31:0]      instret
);

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;
  strobes_t    st, st_g;
  opclass_t    cls;
  logic [4:0]  op;
  logic        gra, grb, grc;
  logic        rin_en, rout_en;
  logic        op_en;
  logic        run_c;

  assign op  = IR[OP_HI:OP_LO];
  assign cls = op_class(op);

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q   <= T0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    st      = '0;
    gra     = 1'b0;
    grb     = 1'b0;
    grc     = 1'b0;
    rin_en  = 1'b0;
    rout_en = 1'b0;
    op_en   = 1'b0;
    run_c   = 1'b1;
    unique case (state_q)
      T0: begin
        if (stop) begin
          run_c = 1'b0;
        end else begin
          st.pcout = 1'b1;
          st.marin = 1'b1;
          st.incpc = 1'b1;
          st.zin   = 1'b1;
          state_d  = T1;
        end
      end
      T1: begin
        st.zlowout = 1'b1;
        st.pcin    = 1'b1;
        st.read    = 1'b1;
        st.mdrin   = 1'b1;
        state_d    = T2;
      end
      T2: begin
        st.mdrout = 1'b1;
        st.irin   = 1'b1;
        unique case (cls)
          CLS_ALU, CLS_MULDIV: state_d = T3;
          CLS_HALT:            state_d = HALTED;
          default: begin
            state_d = T0;
            retire  = 1'b1;
          end
        endcase
      end
      T3: begin
        st.yin  = 1'b1;
        rout_en = 1'b1;
        if (cls == CLS_MULDIV) gra = 1'b1;
        else                   grb = 1'b1;
        state_d = T4;
      end
      T4: begin
        st.zin  = 1'b1;
        rout_en = 1'b1;
        op_en   = 1'b1;
        if (cls == CLS_MULDIV) grb = 1'b1;
        else                   grc = 1'b1;
        state_d = T5;
      end
      T5: begin
        st.zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          st.loin = 1'b1;
          state_d = T6;
        end else begin
          rin_en  = 1'b1;
          gra     = 1'b1;
          retire  = 1'b1;
          state_d = T0;
        end
      end
      T6: begin
        st.zhighout = 1'b1;
        st.hiin     = 1'b1;
        retire      = 1'b1;
        state_d     = T0;
      end
      HALTED: begin
        run_c = 1'b0;
      end
      default: begin
        run_c   = 1'b0;
        state_d = T0;
      end
    endcase
  end

  // Reset blanks every output combinationally, no clock needed.
  assign st_g = clear ? st : '0;

  reg_select_decoder #(
    .NREGS (NREGS)
  ) u_regsel (
    .IR      (IR),
    .Gra     (gra),
    .Grb     (grb),
    .Grc     (grc),
    .Rin_en  (rin_en & clear),
    .Rout_en (rout_en & clear),
    .Rin     (Rin),
    .Rout    (Rout)
  );

  assign PCout    = st_g.pcout;
  assign MARin    = st_g.marin;
  assign IncPC    = st_g.incpc;
  assign Zin      = st_g.zin;
  assign Zlowout  = st_g.zlowout;
  assign Zhighout = st_g.zhighout;
  assign PCin     = st_g.pcin;
  assign Read     = st_g.read;
  assign MDRin    = st_g.mdrin;
  assign MDRout   = st_g.mdrout;
  assign IRin     = st_g.irin;
  assign Yin      = st_g.yin;
  assign HIin     = st_g.hiin;
  assign LOin     = st_g.loin;

  assign opcode  = (op_en && clear) ? OPW'(op) : '0;
  assign run     = run_c & clear;
  assign instret = instret_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer with a
// per-cycle expected-output scoreboard and negedge monitor.
module tb_control_sequencer;

  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_MARIN  = 14'h1000;
  localparam logic [13:0] S_INCPC  = 14'h0800;
  localparam logic [13:0] S_ZIN    = 14'h0400;
  localparam logic [13:0] S_ZLOW   = 14'h0200;
  localparam logic [13:0] S_ZHIGH  = 14'h0100;
  localparam logic [13:0] S_PCIN   = 14'h0080;
  localparam logic [13:0] S_READ   = 14'h0040;
  localparam logic [13:0] S_MDRIN  = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010;
  localparam logic [13:0] S_IRIN   = 14'h0008;
  localparam logic [13:0] S_YIN    = 14'h0004;
  localparam logic [13:0] S_HIIN   = 14'h0002;
  localparam logic [13:0] S_LOIN   = 14'h0001;

  localparam logic [13:0] F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [13:0] F_T1 = S_ZLOW | S_PCIN | S_READ | S_MDRIN;
  localparam logic [13:0] F_T2 = S_MDROUT | S_IRIN;

  logic        Clock;
  logic        clear;
  logic [31:0] IR;
  logic        stop;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
  logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic        run;
  logic [31:0] instret;

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
    logic        run;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   ntests = 0;
  int   nfail  = 0;
  logic done   = 1'b0;

  control_sequencer dut (
    .Clock    (Clock),
    .clear    (clear),
    .IR       (IR),
    .stop     (stop),
    .PCout    (PCout),
    .MARin    (MARin),
    .IncPC    (IncPC),
    .Zin      (Zin),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .PCin     (PCin),
    .Read     (Read),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Yin      (Yin),
    .HIin     (HIin),
    .LOin     (LOin),
    .Rin      (Rin),
    .Rout     (Rout),
    .opcode   (opcode),
    .run      (run),
    .instret  (instret)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc = cyc + 1;

  // Monitor: pops expectations due this cycle, compares mid-cycle.
  initial begin : monitor
    exp_t        e;
    logic [13:0] s;
    forever begin
      @(negedge Clock);
      s = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
           Read, MDRin, MDRout, IRin, Yin, HIin, LOin};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        ntests++;
        if (e.cyc != cyc) begin
          nfail++;
          $display("FAIL %s: checked at cycle %0d, required cycle %0d",
                   e.tag, cyc, e.cyc);
        end else if ({s, Rin, Rout, opcode, run, instret} !==
                     {e.strb, e.rin, e.rout, e.opc, e.run, e.cnt}) begin
          nfail++;
          $display("FAIL %s: got strb=%h rin=%h rout=%h op=%b run=%b ir=%0d, want strb=%h rin=%h rout=%h op=%b run=%b ir=%0d",
                   e.tag, s, Rin, Rout, opcode, run, instret,
                   e.strb, e.rin, e.rout, e.opc, e.run, e.cnt);
        end
      end
    end
  end

  // Push this cycle's expectation, then advance one clock.
  task automatic ex(input string tag, input logic [13:0] strb,
                    input logic [15:0] rin, input logic [15:0] rout,
                    input logic [4:0] opc, input logic r,
                    input logic [31:0] cnt);
    exp_t e;
    e.cyc  = cyc;
    e.tag  = tag;
    e.strb = strb;
    e.rin  = rin;
    e.rout = rout;
    e.opc  = opc;
    e.run  = r;
    e.cnt  = cnt;
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] cnt);
    ex({tag, ".T0"}, F_T0, 16'h0, 16'h0, 5'b0, 1'b1, cnt);
    ex({tag, ".T1"}, F_T1, 16'h0, 16'h0, 5'b0, 1'b1, cnt);
    ex({tag, ".T2"}, F_T2, 16'h0, 16'h0, 5'b0, 1'b1, cnt);
  endtask

  initial begin : stim
    clear = 1'b0;
    stop  = 1'b0;
    IR    = 32'h0;
    @(posedge Clock);
    #1;
    ex("reset", 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 32'd0);
    clear = 1'b1;

    IR = 32'h18918000;
    fetch("add", 0);
    ex("add.T3", S_YIN, 16'h0, 16'h0004, 5'b0, 1'b1, 0);
    ex("add.T4", S_ZIN, 16'h0, 16'h0008, 5'b00011, 1'b1, 0);
    ex("add.T5", S_ZLOW, 16'h0002, 16'h0, 5'b0, 1'b1, 0);

    IR = 32'h48918000;
    for (int i = 0; i < 2; i++) begin
      fetch("rol", 32'(1 + i));
      ex("rol.T3", S_YIN, 16'h0, 16'h0004, 5'b0, 1'b1, 32'(1 + i));
      ex("rol.T4", S_ZIN, 16'h0, 16'h0008, 5'b01001, 1'b1, 32'(1 + i));
      ex("rol.T5", S_ZLOW, 16'h0002, 16'h0, 5'b0, 1'b1, 32'(1 + i));
    end

    IR = 32'h72280000;
    fetch("mul", 3);
    ex("mul.T3", S_YIN, 16'h0, 16'h0010, 5'b0, 1'b1, 3);
    ex("mul.T4", S_ZIN, 16'h0, 16'h0020, 5'b01110, 1'b1, 3);
    ex("mul.T5", S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'b0, 1'b1, 3);
    ex("mul.T6", S_ZHIGH | S_HIIN, 16'h0, 16'h0, 5'b0, 1'b1, 3);

    IR = 32'hD0000000;
    fetch("nop", 4);
    IR = 32'h00000000;
    fetch("unk", 5);

    stop = 1'b1;
    for (int i = 0; i < 5; i++)
      ex("stop.T0", 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 6);
    stop = 1'b0;
    IR = 32'h18918000;
    fetch("resume", 6);
    stop = 1'b1;
    ex("midstop.T3", S_YIN, 16'h0, 16'h0004, 5'b0, 1'b1, 6);
    ex("midstop.T4", S_ZIN, 16'h0, 16'h0008, 5'b00011, 1'b1, 6);
    stop = 1'b0;
    ex("midstop.T5", S_ZLOW, 16'h0002, 16'h0, 5'b0, 1'b1, 6);

    IR = 32'h78000000;
    fetch("div", 7);
    ex("div.T3", S_YIN, 16'h0, 16'h0001, 5'b0, 1'b1, 7);
    ex("div.T4", S_ZIN, 16'h0, 16'h0001, 5'b01111, 1'b1, 7);
    ex("div.T5", S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'b0, 1'b1, 7);
    ex("div.T6", S_ZHIGH | S_HIIN, 16'h0, 16'h0, 5'b0, 1'b1, 7);

    IR = 32'h18918000;
    fetch("clr", 8);
    ex("clr.T3", S_YIN, 16'h0, 16'h0004, 5'b0, 1'b1, 8);
    clear = 1'b0;
    ex("clr.inT4", 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 0);
    ex("clr.hold", 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 0);
    clear = 1'b1;
    ex("clr.T0", F_T0, 16'h0, 16'h0, 5'b0, 1'b1, 0);
    ex("clr.T1", F_T1, 16'h0, 16'h0, 5'b0, 1'b1, 0);
    IR = 32'hD8000000;
    ex("halt.T2", F_T2, 16'h0, 16'h0, 5'b0, 1'b1, 0);
    for (int i = 0; i < 20; i++)
      ex("halted", 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 0);
    clear = 1'b0;
    ex("halt.clr", 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 0);
    clear = 1'b1;
    ex("halt.T0", F_T0, 16'h0, 16'h0, 5'b0, 1'b1, 0);

    @(posedge Clock);
    #1;
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d expectations left, required 0",
               sb.size());
    end
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      begin
        #100000;
        ntests++;
        nfail++;
        $display("FAIL timeout: stimulus did not complete");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the datapath.
- Steps through the fetch/execute micro-steps T0..T6 and asserts the datapath's register-transfer strobes (PCout, MARin, Zin, ...), so the datapath no longer needs a bench to hand-drive them.
- Decodes the instruction held in IR into one-hot register in/out enables and the ALU opcode.
- Supports R-format ALU ops, mul/div via HI/LO, nop and halt.

Parameters:
- NREGS, 16, number of general registers (width of Rin/Rout).
- OPW, 5, opcode width, taken from IR[31:27].

Ports:
- Clock  in  1  system clock, rising-edge.
- clear  in  1  reset, asynchronous, active-low (0 = reset).
- IR  in  32  current instruction register contents from the datapath.
- stop  in  1  request to pause at the next instruction boundary.
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- Rin  out  NREGS  one-hot register load enables (R0in..R15in).
- Rout  out  NREGS  one-hot register drive enables (R0out..R15out).
- opcode  out  OPW  ALU operation select.
- run  out  1  high while the sequencer is executing (not halted, not paused).
- instret  out  32  count of retired instructions.

Behaviour:
- IR field layout: op = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, rol 01001, ror 01010, mul 01110, div 01111, nop 11010, halt 11011. Any other value executes as nop.
- States: T0, T1, T2, T3, T4, T5, T6, HALTED. One state per clock; state register updates on rising Clock.
- Outputs are Moore-decoded from state plus IR. Every strobe not listed for a state is 0. opcode = 00000 except in T4.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Memory data is valid in the same cycle.
  - T2: MDRout, IRin.
- R-format ALU ops (add..ror):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], opcode = op, Zin.
  - T5: Zlowout, Rin[Ra]. Retire, then go to T0.
- mul/div:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], opcode = op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Retire, then go to T0.
- nop/unknown: T2 goes directly to T0 and counts as retired.
- halt: T2 goes to HALTED. Stays in HALTED with all strobes 0 and run = 0 until clear is asserted. Not counted as retired.
- stop:
  - Sampled only in T0.
  - If stop = 1 in T0: all strobes are suppressed to 0, run = 0, state stays T0.
  - Fetch resumes on the first T0 cycle with stop = 0.
  - stop asserted mid-instruction has no effect until the next T0.
- instret: increments by 1 on the clock edge leaving the final step. Wraps 0xFFFFFFFF -> 0.
- Reset (clear = 0), asynchronous at any time including mid-instruction:
  - state = T0, instret = 0.
  - All strobes, Rin, Rout and opcode are forced to 0 immediately while clear = 0, with no clock needed.
  - run = 0 while in reset. After release, run = 1 from the first T0.
- Rin and Rout are always one-hot or zero, never multi-hot. Ra = Rb is legal.

Decomposition:
- Shared package cpu_defs holds:
  - opcode localparams;
  - state encoding (4-bit: T0 = 0 .. T6 = 6, HALTED = 15);
  - IR field bit positions.
- One sub-module, reg_select_decoder: inputs IR, Gra, Grb, Grc, Rin_en, Rout_en; outputs one-hot Rin[15:0] and Rout[15:0] (4-to-16 decode of the selected field).

Test Plan:
- add R1,R2,R3: IR = 0x18918000 after reset -> T3 Rout = 0x0004, Yin = 1; T4 Rout = 0x0008, opcode = 00011, Zin = 1; T5 Rin = 0x0002, Zlowout = 1; instret = 1 at next T0.
- rol R1,R2,R3: IR = 0x48918000 -> T4 opcode = 01001; 6 cycles per instruction; back-to-back issue gives instret = 2 after 12 cycles.
- mul R4,R5: IR = 0x72280000 -> T3 Rout = 0x0010; T4 Rout = 0x0020, opcode = 01110; T5 LOin = 1; T6 Zhighout = 1, HIin = 1; 7 cycles.
- halt: IR = 0xD8000000 -> after T2, HALTED, run = 0, all strobes 0 for 20 cycles; clear pulse returns to T0 with PCout = 1.
- stop held 5 cycles at T0 -> state stays T0 with PCout = MARin = 0; on release, T1 follows on the next edge.
- clear driven low during T4 of add -> Zin and Rout drop to 0 before the next clock edge; after release, state = T0 and instret = 0.
